// File: rtl/writeback_if.sv
// Bundle between the execute/memory paths, decode and the register-file write port.
interface writeback_if #(
  parameter int WIDTH        = 32,
  parameter int REGNUM       = 8,
  parameter int ADDRESSWIDTH = 3,
  parameter int DEPTH        = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                    aluValid;
  logic [ADDRESSWIDTH-1:0] aluAddress;
  logic [WIDTH-1:0]        aluData;
  logic                    memValid;
  logic [ADDRESSWIDTH-1:0] memAddress;
  logic [WIDTH-1:0]        memData;
  logic                    memReady;
  logic                    issueValid;
  logic [ADDRESSWIDTH-1:0] issueAddress;
  logic                    writeEnable;
  logic [ADDRESSWIDTH-1:0] writeAddress;
  logic [WIDTH-1:0]        dataToSave;
  logic [REGNUM-1:0]       pendingMask;
  logic [CW-1:0]           fifoCount;

  modport slave (
    input  aluValid, aluAddress, aluData,
    input  memValid, memAddress, memData,
    input  issueValid, issueAddress,
    output memReady, writeEnable, writeAddress, dataToSave, pendingMask, fifoCount
  );

  modport master (
    output aluValid, aluAddress, aluData,
    output memValid, memAddress, memData,
    output issueValid, issueAddress,
    input  memReady, writeEnable, writeAddress, dataToSave, pendingMask, fifoCount
  );
endinterface

// File: rtl/writeback_unit.sv
// Serialises ALU and buffered memory results onto the single register-file
// write port and tracks which destinations still await their result.
module writeback_unit #(
  parameter int WIDTH        = 32,
  parameter int REGNUM       = 8,
  parameter int ADDRESSWIDTH = 3,
  parameter int DEPTH        = 4
) (
  input  logic        clock,
  input  logic        reset,
  writeback_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDRESSWIDTH-1:0] fifoAddress [DEPTH];
  logic [WIDTH-1:0]        fifoData    [DEPTH];
  logic [PW-1:0]           head;
  logic [PW-1:0]           tail;
  logic [CW-1:0]           count;
  logic                    enqueue;
  logic                    dequeue;
  logic [REGNUM-1:0]       setMask;
  logic [REGNUM-1:0]       clearMask;

  // A full FIFO refuses even on a draining cycle, keeping memReady off the pop path.
  assign bus.memReady  = (count != CW'(DEPTH));
  assign bus.fifoCount = count;
  assign enqueue       = bus.memValid && bus.memReady;
  assign dequeue       = !bus.aluValid && (count != '0);

  always_comb begin
    setMask   = '0;
    clearMask = '0;
    if (bus.issueValid)
      setMask = REGNUM'(1) << bus.issueAddress;
    if (bus.writeEnable)
      clearMask = REGNUM'(1) << bus.writeAddress;
  end

  always_ff @(posedge clock) begin
    if (enqueue) begin
      fifoAddress[tail] <= bus.memAddress;
      fifoData[tail]    <= bus.memData;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      bus.writeEnable  <= 1'b0;
      bus.writeAddress <= '0;
      bus.dataToSave   <= '0;
      bus.pendingMask  <= '0;
    end else begin
      if (enqueue)
        tail <= tail + PW'(1);
      if (dequeue)
        head <= head + PW'(1);

      case ({enqueue, dequeue})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (bus.aluValid) begin
        bus.writeEnable  <= 1'b1;
        bus.writeAddress <= bus.aluAddress;
        bus.dataToSave   <= bus.aluData;
      end else if (dequeue) begin
        bus.writeEnable  <= 1'b1;
        bus.writeAddress <= fifoAddress[head];
        bus.dataToSave   <= fifoData[head];
      end else begin
        bus.writeEnable  <= 1'b0;
      end

      // A fresh issue to a register being written keeps it pending for the newer instruction.
      bus.pendingMask <= (bus.pendingMask & ~clearMask) | setMask;
    end
  end
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Write-side counterpart of the decode stage.
- Collects completed results from the ALU path and the memory/IO path, and serialises them onto the single register-file write port (writeEnable, writeAddress, dataToSave).
- Keeps a per-register pending scoreboard so decode can detect RAW hazards on issued destinations.
- Memory results are buffered in a small FIFO. ALU results take the write port directly with priority.

Parameters:
- WIDTH, 32, data width of register values
- REGNUM, 8, number of architectural registers; width of the scoreboard
- ADDRESSWIDTH, 3, register address width
- DEPTH, 4, memory-result FIFO entries (power of two, >=2)

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- aluValid  input  1  ALU result present this cycle; always accepted
- aluAddress  input  ADDRESSWIDTH  ALU destination register
- aluData  input  WIDTH  ALU result
- memValid  input  1  memory/IO result offered
- memAddress  input  ADDRESSWIDTH  memory destination register
- memData  input  WIDTH  memory result
- memReady  output  1  FIFO can accept; transfer occurs when memValid && memReady at a rising edge
- issueValid  input  1  decode issued an instruction writing issueAddress
- issueAddress  input  ADDRESSWIDTH  destination being issued (decode's regDestinationAddress)
- writeEnable  output  1  register-file write strobe (registered)
- writeAddress  output  ADDRESSWIDTH  register-file write address (registered)
- dataToSave  output  WIDTH  register-file write data (registered)
- pendingMask  output  REGNUM  bit i = 1 while register i has an issued, unwritten result
- fifoCount  output  clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (async, any time, including mid-drain):
  - writeEnable=0, writeAddress=0, dataToSave=0, pendingMask=0, fifoCount=0.
  - FIFO pointers cleared; buffered contents discarded.
  - memReady=1 immediately.
- memReady is combinational: memReady = (fifoCount != DEPTH). It does not depend on a same-cycle dequeue; a full FIFO refuses even while draining.
- Enqueue: at an edge with memValid && memReady, {memAddress, memData} is written at the tail; fifoCount increments.
- Write-port arbitration, evaluated each edge:
  - If aluValid: the output register loads {1, aluAddress, aluData}. The FIFO does not dequeue.
  - Else if the FIFO is non-empty (count before this edge > 0): the head is popped and loaded as {1, addr, data}; fifoCount decrements.
  - Else: writeEnable=0. writeAddress and dataToSave hold their previous values.
- Simultaneous enqueue and dequeue on one edge: fifoCount unchanged, pointers both advance.
- Latency:
  - ALU result at edge t appears with writeEnable=1 in the cycle after edge t (1 cycle).
  - A memory result enqueued into an empty FIFO at edge t is written after edge t+1, provided aluValid=0 at t+1 (minimum 2 cycles).
  - Each additional ALU cycle delays the FIFO by one cycle. The FIFO preserves arrival order.
- Pointer wrap-around: head and tail wrap modulo DEPTH. Full and empty are distinguished by fifoCount, not by pointer equality.
- Scoreboard, per edge, for each register i:
  - set if issueValid && issueAddress==i;
  - cleared if writeEnable (current registered output) && writeAddress==i;
  - set wins when both happen on the same register (a newer instruction is outstanding).
  - Register 0 is tracked like any other.
- Multiple outstanding writes to one register are not counted. The first write clears the bit. Decode must stall issue on a set bit, so this case does not arise in legal operation.
- No combinational path from aluValid or memValid to writeEnable.

Test Plan:
1. Reset check: assert reset mid-operation with fifoCount=3 and pendingMask=8'h0C → all outputs 0 and memReady=1 asynchronously. After release, no stale writes appear.
2. ALU single write: issueValid, issueAddress=5 at edge 0 → pendingMask=8'h20. aluValid, aluAddress=5, aluData=32'hDEADBEEF at edge 1 → after edge 1, writeEnable=1, writeAddress=5, dataToSave=32'hDEADBEEF. After edge 2, pendingMask=0 and writeEnable=0.
3. Memory ordering: enqueue (2,32'h11), (3,32'h22), (4,32'h33) on consecutive edges, aluValid=0 → writes occur in order 2, 3, 4 on consecutive cycles, starting the cycle after the second edge. fifoCount peaks at 1.
4. ALU priority and starvation: hold aluValid=1 for 6 cycles while offering 5 memory results → memReady drops after 4 accepts (fifoCount=4), the 5th is held off. Once aluValid=0, the FIFO drains 4 entries in order and the 5th is accepted on the first not-full cycle.
5. Full FIFO with dequeue: fifoCount=4, aluValid=0, memValid=1 → memReady=0 that cycle. The head is written, fifoCount=3, and the offer is accepted on the next edge.
6. Scoreboard collision: pendingMask bit 6 set; on the same edge writeEnable=1, writeAddress=6 and issueValid, issueAddress=6 → bit 6 remains 1.
